din_word_feeder: RTL and testbench

//  Input stage directly upstream of the decompression handler. Captures 16-bit Din words

---
 rtl/din_word_feeder.sv | 186 ++++++++++++++++++
 tb/tb_din_word_feeder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/din_word_feeder.sv
`default_nettype none
// ============================================================================
// Module      : din_word_feeder
// Description : Buffers 16-bit Din words in a small FIFO and launches one
//               decompression job per word as a high/low byte pair.
// Revision    : 1.0 - initial release
// ============================================================================
module din_word_feeder #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          RST,
    input  logic          load,
    input  logic [15:0]   Din,
    input  logic          interrupt,
    input  logic          working,
    input  logic          done,
    output logic [7:0]    in1,
    output logic [7:0]    in2,
    output logic          work,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    localparam logic [AW:0]   c_FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] c_PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    state_t        r_state;
    state_t        w_stateNext;

    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [AW:0]   r_count;
    logic [AW:0]   w_countNext;
    logic          r_full;
    logic          r_empty;
    logic          r_overflow;
    logic          r_work;
    logic [7:0]    r_in1;
    logic [7:0]    r_in2;

    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic          w_workNext;
    logic          w_takeHead;
    logic [15:0]   w_head;

    // Interrupt dominates: no push, no pop, and its load is silently discarded.
    assign w_pop  = (r_state == IDLE) && !r_empty && !working && !interrupt;
    assign w_push = load && !interrupt && (!r_full || w_pop);
    assign w_drop = load && !interrupt && r_full && !w_pop;
    assign w_head = r_mem[r_rdPtr];

    // ------------------------------------------------------------------
    // Job handshake FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_workNext  = 1'b0;
        w_takeHead  = 1'b0;
        if (interrupt) begin
            w_stateNext = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        w_takeHead  = 1'b1;
                        w_workNext  = 1'b1;
                        w_stateNext = LAUNCH;
                    end
                end
                LAUNCH: begin
                    w_stateNext = WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (done) begin
                        w_stateNext = IDLE;
                    end
                end
                default: begin
                    w_stateNext = IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO occupancy
    // ------------------------------------------------------------------
    always_comb begin
        w_countNext = r_count;
        if (interrupt) begin
            w_countNext = '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_countNext = r_count + c_CNT_ONE;
                2'b01:   w_countNext = r_count - c_CNT_ONE;
                default: w_countNext = r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_count <= w_countNext;
            r_full  <= (w_countNext == c_FULL_CNT);
            r_empty <= (w_countNext == '0);
            if (interrupt) begin
                r_wrPtr    <= '0;
                r_rdPtr    <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wrPtr <= r_wrPtr + c_PTR_ONE;
                end
                if (w_pop) begin
                    r_rdPtr <= r_rdPtr + c_PTR_ONE;
                end
                if (w_drop) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    // Storage carries no reset; only slots between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= Din;
        end
    end

    // ------------------------------------------------------------------
    // Job outputs: bytes move only on a pop, work is a one-cycle strobe
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_work <= 1'b0;
            r_in1  <= 8'h00;
            r_in2  <= 8'h00;
        end else begin
            r_work <= w_workNext;
            if (w_takeHead) begin
                r_in1 <= w_head[15:8];
                r_in2 <= w_head[7:0];
            end
        end
    end

    assign in1      = r_in1;
    assign in2      = r_in2;
    assign work     = r_work;
    assign full     = r_full;
    assign empty    = r_empty;
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_din_word_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_din_word_feeder
// Description : Directed self-checking bench for din_word_feeder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_din_word_feeder;

    logic        clk;
    logic        RST;
    logic        load;
    logic [15:0] Din;
    logic        interrupt;
    logic        working;
    logic        done;
    logic [7:0]  in1;
    logic [7:0]  in2;
    logic        work;
    logic        full;
    logic        empty;
    logic [3:0]  count;
    logic        overflow;

    int nChecks = 0;
    int nErrors = 0;

    din_word_feeder #(.DEPTH(8), .AW(3)) dut (
        .clk       (clk),
        .RST       (RST),
        .load      (load),
        .Din       (Din),
        .interrupt (interrupt),
        .working   (working),
        .done      (done),
        .in1       (in1),
        .in2       (in2),
        .work      (work),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nErrors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for the launch strobe, checks the byte pair, then completes the job.
    task automatic runJob(input logic [15:0] exp);
        int n = 0;
        while (work !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("workSeen", {31'd0, work}, 32'd1);
        check("jobData", {16'd0, in1, in2}, {16'd0, exp});
        step();
        check("workPulse", {31'd0, work}, 32'd0);
        done = 1'b1;
        step();
        done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        RST = 1'b1; load = 1'b0; Din = 16'h0; interrupt = 1'b0;
        working = 1'b0; done = 1'b0;
        step(); step();
        RST = 1'b0;
        step();

        // Reset state
        check("rstEmpty", {31'd0, empty}, 32'd1);
        check("rstFull", {31'd0, full}, 32'd0);
        check("rstCount", {28'd0, count}, 32'd0);
        check("rstWork", {31'd0, work}, 32'd0);
        check("rstBytes", {16'd0, in1, in2}, 32'h0);
        check("rstOvf", {31'd0, overflow}, 32'd0);

        // Single word latency
        load = 1'b1; Din = 16'hA55A;
        step();
        load = 1'b0;
        check("latCount1", {28'd0, count}, 32'd1);
        check("latWork0", {31'd0, work}, 32'd0);
        step();
        check("latWork1", {31'd0, work}, 32'd1);
        check("latBytes", {16'd0, in1, in2}, 32'hA55A);
        check("latEmpty", {31'd0, empty}, 32'd1);
        step();
        check("latWorkOff", {31'd0, work}, 32'd0);
        step(); step();
        done = 1'b1;
        step();
        done = 1'b0;
        check("latEmptyEnd", {31'd0, empty}, 32'd1);

        // Fill while busy, overflow on 9th
        working = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            load = 1'b1; Din = 16'(i);
            step();
            if (i == 8) begin
                check("fillFull", {31'd0, full}, 32'd1);
                check("fillCount", {28'd0, count}, 32'd8);
                check("fillOvf0", {31'd0, overflow}, 32'd0);
            end
        end
        check("ovfSet", {31'd0, overflow}, 32'd1);
        check("ovfCount", {28'd0, count}, 32'd8);

        // Push into full FIFO on the same edge as a pop
        working = 1'b0; Din = 16'hBEEF;
        step();
        load = 1'b0;
        check("pushPopCount", {28'd0, count}, 32'd8);
        check("pushPopOvf", {31'd0, overflow}, 32'd1);
        runJob(16'h0001);
        for (int i = 2; i <= 8; i++) begin
            runJob(16'(i));
        end
        runJob(16'hBEEF);
        step();
        check("drainEmpty", {31'd0, empty}, 32'd1);

        // Interrupt with a job in flight and words queued
        for (int i = 1; i <= 4; i++) begin
            load = 1'b1; Din = 16'(i * 16'h1111);
            step();
        end
        load = 1'b0;
        step();
        check("intPreCount", {28'd0, count}, 32'd3);
        check("intPreOvf", {31'd0, overflow}, 32'd1);
        interrupt = 1'b1; load = 1'b1; Din = 16'hDEAD;
        step();
        interrupt = 1'b0; load = 1'b0;
        check("intCount", {28'd0, count}, 32'd0);
        check("intEmpty", {31'd0, empty}, 32'd1);
        check("intOvf", {31'd0, overflow}, 32'd0);
        check("intBytesHeld", {16'd0, in1, in2}, 32'h1111);
        done = 1'b1;
        step();
        done = 1'b0;
        check("intDoneCount", {28'd0, count}, 32'd0);
        check("intDoneWork", {31'd0, work}, 32'd0);
        load = 1'b1; Din = 16'h5555;
        step();
        load = 1'b0;
        step();
        check("postIntWork", {31'd0, work}, 32'd1);
        check("postIntBytes", {16'd0, in1, in2}, 32'h5555);

        // done during LAUNCH must not end the job
        done = 1'b1;
        step();
        done = 1'b0;
        load = 1'b1; Din = 16'h6666;
        step();
        load = 1'b0;
        step(); step();
        check("launchDoneWork", {31'd0, work}, 32'd0);
        check("launchDoneCount", {28'd0, count}, 32'd1);
        done = 1'b1;
        step();
        done = 1'b0;
        runJob(16'h6666);

        // Asynchronous reset mid-job with 5 words queued
        for (int i = 1; i <= 6; i++) begin
            load = 1'b1; Din = 16'(16'h7000 + i);
            step();
        end
        load = 1'b0;
        check("arstPreCount", {28'd0, count}, 32'd5);
        #2;
        RST = 1'b1;
        #1;
        check("arstCount", {28'd0, count}, 32'd0);
        check("arstEmpty", {31'd0, empty}, 32'd1);
        check("arstFull", {31'd0, full}, 32'd0);
        check("arstWork", {31'd0, work}, 32'd0);
        check("arstBytes", {16'd0, in1, in2}, 32'h0);
        check("arstOvf", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        RST = 1'b0;
        step();

        // Pointer wrap-around keeps order
        for (int i = 0; i < 20; i++) begin
            load = 1'b1; Din = 16'(16'hC000 + i * 3);
            step();
            load = 1'b0;
            runJob(16'(16'hC000 + i * 3));
        end
        step();
        check("wrapEmpty", {31'd0, empty}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
`default_nettype wire
